// File: rtl/dsp_addr_sequencer.sv
// dsp_addr_sequencer: loop sequencer driving addr_gen and MAC control.
// Walks N_SERIES x N_STATES x (STATE_TAPS+COMMON_TAPS) operand reads.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, abort      run request (IDLE only), synchronous abort
//   addr_sel          to addr_gen: [0] inc st, [1] rst st, [2] inc cm, [3] rst cm
//   addr_ptr          to addr_gen: {bank, tap offset}
//   series_inc/rst    to addr_gen: series offset advance / clear
//   busy, done        run in progress, 1-cycle completion pulse
//   acc_valid/first/last  MAC flags aligned with addr_gen addr_out
module dsp_addr_sequencer #(
  parameter int OFFSET_WIDTH = 3,
  parameter int N_STATES     = 4,
  parameter int STATE_TAPS   = 4,
  parameter int COMMON_TAPS  = 2,
  parameter int N_SERIES     = 3,
  parameter int ADDR_LAT     = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [3:0]              addr_sel,
  output logic [OFFSET_WIDTH-1:0] addr_ptr,
  output logic                    series_inc,
  output logic                    series_rst,
  output logic                    busy,
  output logic                    acc_valid,
  output logic                    acc_first,
  output logic                    acc_last,
  output logic                    done
);

  localparam int OW   = OFFSET_WIDTH;
  localparam int TAPS = STATE_TAPS + COMMON_TAPS;
  localparam int SW   = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int RW   = (N_SERIES > 1) ? $clog2(N_SERIES) : 1;
  localparam int CMAX = (GAP_CYCLES > ADDR_LAT) ? GAP_CYCLES : ADDR_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [OW-1:0] TAP_END = OW'(TAPS - 1);
  localparam logic [OW-1:0] ST_TAPS = OW'(STATE_TAPS);
  localparam logic [SW-1:0] ST_END  = SW'(N_STATES - 1);
  localparam logic [RW-1:0] SER_END = RW'(N_SERIES - 1);
  localparam logic [CW-1:0] GAP_END =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LAT_END = CW'(ADDR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN
  } state_t;

  state_t        state, n_state;
  logic [OW-1:0] tap, n_tap;
  logic [SW-1:0] st, n_st;
  logic [RW-1:0] ser, n_ser;
  logic [CW-1:0] cnt, n_cnt;
  logic          kill, fin;

  logic          n_rd, n_tl, n_sl, n_rl;
  logic [2:0]    iss;
  logic [ADDR_LAT-1:0][2:0] dly;

  function automatic logic [OW-1:0] ptr_of(
    input logic [OW-1:0] t
  );
    if (t < ST_TAPS)
      ptr_of = {1'b0, t[OW-2:0]};
    else
      ptr_of = {1'b1, (OW-1)'(t - ST_TAPS)};
  endfunction

  // Counters always describe the read of the
  // coming cycle, so outputs can be registered
  // without adding a cycle of issue latency.
  always_comb begin
    n_state = state;
    n_tap   = tap;
    n_st    = st;
    n_ser   = ser;
    n_cnt   = cnt;
    kill    = 1'b0;
    fin     = 1'b0;
    if (abort && state != IDLE) begin
      n_state = IDLE;
      n_tap   = '0;
      n_st    = '0;
      n_ser   = '0;
      n_cnt   = '0;
      kill    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort)
            n_state = RUN;
        end
        RUN: begin
          if (tap == TAP_END) begin
            n_tap = '0;
            if (st != ST_END) begin
              n_st = st + 1'b1;
            end else begin
              n_st  = '0;
              n_cnt = '0;
              if (ser != SER_END) begin
                n_ser   = ser + 1'b1;
                n_state = (GAP_CYCLES > 0) ? GAP : RUN;
              end else begin
                n_ser   = '0;
                n_state = DRAIN;
              end
            end
          end else begin
            n_tap = tap + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            n_state = RUN;
            n_cnt   = '0;
          end else begin
            n_cnt = cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == LAT_END) begin
            n_state = IDLE;
            n_cnt   = '0;
            fin     = 1'b1;
          end else begin
            n_cnt = cnt + 1'b1;
          end
        end
        default: n_state = IDLE;
      endcase
    end
  end

  assign n_rd = (n_state == RUN);
  assign n_tl = n_rd && (n_tap == TAP_END);
  assign n_sl = n_tl && (n_st == ST_END);
  assign n_rl = n_sl && (n_ser == SER_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tap        <= '0;
      st         <= '0;
      ser        <= '0;
      cnt        <= '0;
      addr_sel   <= '0;
      addr_ptr   <= '0;
      series_inc <= 1'b0;
      series_rst <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iss        <= '0;
      dly        <= '0;
    end else begin
      state <= n_state;
      tap   <= n_tap;
      st    <= n_st;
      ser   <= n_ser;
      cnt   <= n_cnt;

      // Last tap of the last state resets both
      // bank counters; addr_gen still uses the
      // old count for this cycle's read.
      if (kill || n_sl)
        addr_sel <= 4'b1010;
      else if (n_tl)
        addr_sel <= 4'b0101;
      else
        addr_sel <= 4'b0000;

      series_inc <= n_sl && !n_rl;
      series_rst <= kill || n_rl;

      if (n_rd)
        addr_ptr <= ptr_of(n_tap);

      busy <= (n_state != IDLE);
      done <= fin;

      iss <= {n_rd, n_rd && (n_tap == '0), n_tl};
      if (kill) begin
        dly <= '0;
      end else begin
        dly[0] <= iss;
        for (int i = 1; i < ADDR_LAT; i++)
          dly[i] <= dly[i-1];
      end
    end
  end

  assign acc_valid = dly[ADDR_LAT-1][2];
  assign acc_first = dly[ADDR_LAT-1][1];
  assign acc_last  = dly[ADDR_LAT-1][0];

endmodule

// File: tb/tb_dsp_addr_sequencer.sv
// tb_dsp_addr_sequencer: bench for dsp_addr_sequencer with a schedule model,
// an addr_gen model for alignment, and directed literal checks.
module tb_dsp_addr_sequencer;

  localparam int NT      = 6;
  localparam int NST     = 4;
  localparam int NSER    = 3;
  localparam int GAP     = 2;
  localparam int LAT     = 3;
  localparam int SER_LEN = NST * NT + GAP;
  localparam int RUN_LEN =
    1 + NSER * NST * NT + (NSER - 1) * GAP + LAT;

  logic clk = 1'b0;
  logic rst_n, start, abort, start_s, abort_s;

  logic [3:0] addr_sel, addr_sel_s;
  logic [2:0] addr_ptr, addr_ptr_s;
  logic series_inc, series_rst, busy;
  logic acc_valid, acc_first, acc_last, done;
  logic series_inc_s, series_rst_s, busy_s;
  logic acc_valid_s, acc_first_s, acc_last_s, done_s;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int t0   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_addr_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .addr_sel(addr_sel), .addr_ptr(addr_ptr),
    .series_inc(series_inc), .series_rst(series_rst),
    .busy(busy), .acc_valid(acc_valid),
    .acc_first(acc_first), .acc_last(acc_last),
    .done(done)
  );

  dsp_addr_sequencer #(
    .OFFSET_WIDTH(3), .N_STATES(1), .STATE_TAPS(1),
    .COMMON_TAPS(0), .N_SERIES(1), .ADDR_LAT(3),
    .GAP_CYCLES(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .start(start_s), .abort(abort_s),
    .addr_sel(addr_sel_s), .addr_ptr(addr_ptr_s),
    .series_inc(series_inc_s), .series_rst(series_rst_s),
    .busy(busy_s), .acc_valid(acc_valid_s),
    .acc_first(acc_first_s), .acc_last(acc_last_s),
    .done(done_s)
  );

  logic [13:0] vm, vs;
  assign vm = {addr_sel, addr_ptr, series_inc, series_rst,
               busy, acc_valid, acc_first, acc_last, done};
  assign vs = {addr_sel_s, addr_ptr_s, series_inc_s,
               series_rst_s, busy_s, acc_valid_s,
               acc_first_s, acc_last_s, done_s};

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @cyc %0d",
               nm, got, exp, cyc);
    end
  endtask

  // Read index k cycles after start -> (tap, state, series).
  function automatic bit rd(input int kk, output int tap,
                            output int st, output int ser);
    int j, w;
    tap = 0; st = 0; ser = 0;
    if (kk < 1) return 1'b0;
    j   = kk - 1;
    ser = j / SER_LEN;
    w   = j % SER_LEN;
    if (ser >= NSER || w >= NST * NT) return 1'b0;
    tap = w % NT;
    st  = w / NT;
    return 1'b1;
  endfunction

  function automatic int exp_addr(input int tap, input int st,
                                  input int ser);
    if (tap < 4) return ser * 16 + st * 4 + tap;
    return ser * 16 + 64 + st * 2 + (tap - 4);
  endfunction

  // Run tracker: k counts cycles since the start cycle.
  bit run_m, ab_m;
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_m <= 1'b0; ab_m <= 1'b0; k <= 0;
    end else begin
      ab_m <= 1'b0;
      if ((!run_m || k >= RUN_LEN) && start && !abort) begin
        run_m <= 1'b1; k <= 1;
      end else if (run_m && k < RUN_LEN && abort) begin
        run_m <= 1'b0; ab_m <= 1'b1; k <= 0;
      end else if (run_m) begin
        if (k >= RUN_LEN) run_m <= 1'b0;
        else k <= k + 1;
      end
    end
  end

  // addr_gen model: STATES +4, COMMON +2, SERIES +16, 3-cycle latency.
  int ag_s, ag_c, ag_r;
  int ag_p [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ag_s <= 0; ag_c <= 0; ag_r <= 0;
      ag_p[0] <= 0; ag_p[1] <= 0; ag_p[2] <= 0;
    end else begin
      ag_p[0] <= ag_r + (addr_ptr[2] ? 64 + ag_c : ag_s)
                 + int'(addr_ptr[1:0]);
      ag_p[1] <= ag_p[0];
      ag_p[2] <= ag_p[1];
      if (addr_sel[1]) ag_s <= 0;
      else if (addr_sel[0]) ag_s <= ag_s + 4;
      if (addr_sel[3]) ag_c <= 0;
      else if (addr_sel[2]) ag_c <= ag_c + 2;
      if (series_rst) ag_r <= 0;
      else if (series_inc) ag_r <= ag_r + 16;
    end
  end

  logic [2:0] last_ptr;
  bit log_en = 1'b0;
  int q_sel[$], q_inc[$], q_rst[$], q_ptr[$];
  int q_first[$], q_last[$];
  int acc_n, done_n, rise_n, a43;
  logic busy_d;

  always @(negedge clk) begin
    int tp, sp, rp, ta, sa, ra, rel;
    bit rv, av;
    logic [3:0] e_sel;
    logic e_inc, e_rst, e_busy, e_done;
    logic [13:0] ev;
    if (!rst_n) begin
      last_ptr = '0;
      busy_d   = 1'b0;
    end else begin
      rv = run_m && rd(k, tp, sp, rp);
      av = run_m && rd(k - LAT, ta, sa, ra);
      e_sel = 4'b0000; e_inc = 1'b0; e_rst = 1'b0;
      if (rv) begin
        last_ptr = (tp < 4) ? 3'(tp) : {1'b1, 2'(tp - 4)};
        if (tp == NT - 1) begin
          if (sp == NST - 1) begin
            e_sel = 4'b1010;
            if (rp == NSER - 1) e_rst = 1'b1;
            else e_inc = 1'b1;
          end else begin
            e_sel = 4'b0101;
          end
        end
      end
      if (ab_m) begin
        e_sel = 4'b1010; e_rst = 1'b1;
      end
      e_busy = run_m && k >= 1 && k < RUN_LEN;
      e_done = run_m && k == RUN_LEN;
      ev = {e_sel, last_ptr, e_inc, e_rst, e_busy, av,
            av && ta == 0, av && ta == NT - 1, e_done};
      check("cycle", 32'(vm), 32'(ev));
      if (av && acc_valid)
        check("addr_out", ag_p[2], exp_addr(ta, sa, ra));

      rel = cyc - t0;
      if (busy && !busy_d) rise_n++;
      busy_d = busy;
      if (done) done_n++;
      if (log_en) begin
        if (addr_sel == 4'b0101) q_sel.push_back(rel);
        if (series_inc) q_inc.push_back(rel);
        if (series_rst) q_rst.push_back(rel);
        if (rel >= 1 && rel <= 7) q_ptr.push_back(int'(addr_ptr));
        if (acc_valid) acc_n++;
        if (acc_valid && acc_first) q_first.push_back(rel);
        if (acc_valid && acc_last) q_last.push_back(rel);
        if (rel == 43) a43 = acc_valid ? ag_p[2] : -1;
      end
    end
  end

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic pulse_start();
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int rel);
    bit found;
    found = 1'b0;
    rel = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        rel = cyc - t0;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic logged_run(output int rel);
    q_sel.delete(); q_inc.delete(); q_rst.delete();
    q_ptr.delete(); q_first.delete(); q_last.delete();
    acc_n = 0; a43 = -2;
    log_en = 1'b1;
    pulse_start();
    wait_done(rel);
    log_en = 1'b0;
  endtask

  logic [13:0] tbl_s [6];

  initial begin
    int rel, dn, rs;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_s = 1'b0; abort_s = 1'b0;
    tbl_s[0] = 14'b1010_000_0_1_1_000_0;
    tbl_s[1] = 14'b0000_000_0_0_1_000_0;
    tbl_s[2] = 14'b0000_000_0_0_1_000_0;
    tbl_s[3] = 14'b0000_000_0_0_1_111_0;
    tbl_s[4] = 14'b0000_000_0_0_0_000_1;
    tbl_s[5] = 14'b0000_000_0_0_0_000_0;
    #1;
    check("reset_main", 32'(vm), 32'd0);
    check("reset_small", 32'(vs), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full default run.
    logged_run(rel);
    check("done_at", rel, 80);
    check("acc_count", acc_n, 72);
    check("sel0101_0", qi(q_sel, 0), 6);
    check("sel0101_1", qi(q_sel, 1), 12);
    check("sel0101_2", qi(q_sel, 2), 18);
    check("series_inc_0", qi(q_inc, 0), 24);
    check("series_inc_1", qi(q_inc, 1), 50);
    check("series_rst", qi(q_rst, 0), 76);
    for (int i = 0; i < 7; i++)
      check("ptr_seq", qi(q_ptr, i), i % 6);
    check("first_acc_first", qi(q_first, 0), 4);
    check("first_acc_last", qi(q_last, 0), 9);
    check("addr_out_25", a43, 25);
    repeat (3) @(negedge clk);

    // Start held 10 cycles plus re-pulse in DRAIN.
    rs = rise_n;
    t0 = cyc;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (68) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(rel);
    check("held_done_at", rel, 80);
    repeat (6) @(negedge clk);
    check("one_run", rise_n - rs, 1);
    check("idle_after", 32'(busy), 32'd0);

    // Abort in series 1, state 2.
    pulse_start();
    repeat (40) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_sel", 32'(addr_sel), 32'b1010);
    check("abort_srst", 32'(series_rst), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_acc", 32'(acc_valid), 32'd0);
    dn = done_n;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_n - dn, 0);

    // Abort and start together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_sel", 32'(addr_sel), 32'd0);
    repeat (2) @(negedge clk);

    // Async reset mid-run, then a full replay.
    pulse_start();
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", 32'(vm), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    logged_run(rel);
    check("replay_done_at", rel, 80);
    check("replay_acc_count", acc_n, 72);
    repeat (3) @(negedge clk);

    // Minimal configuration.
    t0 = cyc;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("small_cycle", 32'(vs), 32'(tbl_s[i]));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
